// File: rtl/mux_seg_pkg.sv
// Shared constants for the multiplexed seven-segment counter: digit width and
// the hex segment patterns ({g,f,e,d,c,b,a}, active-high).
package mux_seg_pkg;

  localparam int DIGIT_W = 4;

  // Entry n is the pattern for hex value n; element 15 sits leftmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/mux_seg_counter_if.sv
// Control/status bundle of mux_seg_counter; the counter core takes the slave
// side, whoever drives enable/load takes the master side.
interface mux_seg_counter_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    up_dn;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] count;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    tick;
  logic                    wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  count, seg, dig_sel, tick, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, seg, dig_sel, tick, wrap
  );
endinterface

// File: rtl/mux_seg_counter_hex7_decoder.sv
// Combinational 4-bit value to seven-segment pattern lookup.
module hex7_decoder
  import mux_seg_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_val,
  output logic [6:0]         o_seg
);

  assign o_seg = SEG_TABLE[i_val];

endmodule

// File: rtl/mux_seg_counter.sv
// Prescaled cascaded BCD/hex counter with multiplexed seven-segment scan-out.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module mux_seg_counter
  import mux_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int RADIX      = 10,
  parameter int TICK_DIV   = 10_000_000,
  parameter int SCAN_DIV   = 10_000
) (
  input  logic            clk,
  input  logic            reset,
  mux_seg_counter_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = DIGIT_W * NUM_DIGITS;
  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(RADIX - 1);

  logic [PW-1:0]         r_presc;
  logic [CW-1:0]         r_count;
  logic [SW-1:0]         r_scan_cnt;
  logic [IW-1:0]         r_scan_idx;
  logic [NUM_DIGITS-1:0] r_dig_sel;
  logic [6:0]            r_seg;

  logic                  w_presc_tc;
  logic                  w_step;
  logic                  w_carry;
  logic [CW-1:0]         w_next;
  logic [CW-1:0]         w_load_clamped;
  logic [DIGIT_W-1:0]    w_sel_digit;
  logic [6:0]            w_dec_seg;
  logic                  w_blank_sel;

  assign w_presc_tc = (r_presc == PW'(TICK_DIV - 1));
  assign w_step     = ~reset & ~bus.load & bus.en & w_presc_tc;

  // Ripple carry/borrow from digit 0; w_carry left set means every digit wrapped.
  always_comb begin
    w_next  = r_count;
    w_carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_carry) begin
        if (bus.up_dn) begin
          if (r_count[DIGIT_W*i +: DIGIT_W] == MAX_D) begin
            w_next[DIGIT_W*i +: DIGIT_W] = '0;
          end else begin
            w_next[DIGIT_W*i +: DIGIT_W] = r_count[DIGIT_W*i +: DIGIT_W] + DIGIT_W'(1);
            w_carry = 1'b0;
          end
        end else begin
          if (r_count[DIGIT_W*i +: DIGIT_W] == '0) begin
            w_next[DIGIT_W*i +: DIGIT_W] = MAX_D;
          end else begin
            w_next[DIGIT_W*i +: DIGIT_W] = r_count[DIGIT_W*i +: DIGIT_W] - DIGIT_W'(1);
            w_carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_load_clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_load_clamped[DIGIT_W*i +: DIGIT_W] =
        (bus.load_val[DIGIT_W*i +: DIGIT_W] > MAX_D) ? MAX_D : bus.load_val[DIGIT_W*i +: DIGIT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (bus.load) begin
      r_presc <= '0;
      r_count <= w_load_clamped;
    end else if (bus.en) begin
      if (w_presc_tc) begin
        r_presc <= '0;
        r_count <= w_next;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Scan runs regardless of en so the display never freezes on one digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_scan_idx <= (r_scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + IW'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SW'(1);
    end
  end

  assign w_sel_digit = r_count[DIGIT_W*int'(r_scan_idx) +: DIGIT_W];

  hex7_decoder u_dec (
    .i_val (w_sel_digit),
    .o_seg (w_dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_zero_above;

  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above & (r_count[DIGIT_W*i +: DIGIT_W] == '0);
      w_blank[i]   = w_zero_above;
    end
  end

  assign w_blank_sel = w_blank[r_scan_idx];
`else
  assign w_blank_sel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dig_sel <= '0;
      r_seg     <= '0;
    end else begin
      r_dig_sel <= NUM_DIGITS'(1) << r_scan_idx;
      r_seg     <= w_blank_sel ? 7'h00 : w_dec_seg;
    end
  end

  assign bus.count   = r_count;
  assign bus.seg     = r_seg;
  assign bus.dig_sel = r_dig_sel;
  assign bus.tick    = w_step;
  assign bus.wrap    = w_step & w_carry;

endmodule

// File: tb/tb_mux_seg_counter.sv
// Directed bench: instance A is 2-digit decimal, instance B is 4-digit hex, both TICK_DIV=4, SCAN_DIV=2.
module tb_mux_seg_counter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mux_seg_counter_if #(.NUM_DIGITS(2)) if_a ();
  mux_seg_counter_if #(.NUM_DIGITS(4)) if_b ();

  mux_seg_counter #(.NUM_DIGITS(2), .RADIX(10), .TICK_DIV(4), .SCAN_DIV(2)) u_dut_a (
    .clk (clk), .reset (reset), .bus (if_a)
  );
  mux_seg_counter #(.NUM_DIGITS(4), .RADIX(16), .TICK_DIV(4), .SCAN_DIV(2)) u_dut_b (
    .clk (clk), .reset (reset), .bus (if_b)
  );

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_a.en = 1'b0; if_a.up_dn = 1'b1; if_a.load = 1'b0; if_a.load_val = '0;
    if_b.en = 1'b0; if_b.up_dn = 1'b1; if_b.load = 1'b0; if_b.load_val = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] bcd2(int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic test_reset();
    if_a.en = 1'b1; if_a.load = 1'b1; if_a.load_val = 8'h55;
    if_b.en = 1'b1; if_b.load = 1'b1; if_b.load_val = 16'h1234;
    reset = 1'b1;
    step();
    step();
    n_checks++; if (if_a.count !== 8'h00) $display("FAIL rst_count_a got %h exp 00", if_a.count); else n_pass++;
    n_checks++; if (if_a.tick !== 1'b0) $display("FAIL rst_tick_a got %b exp 0", if_a.tick); else n_pass++;
    n_checks++; if (if_a.wrap !== 1'b0) $display("FAIL rst_wrap_a got %b exp 0", if_a.wrap); else n_pass++;
    n_checks++; if (if_a.seg !== 7'h00) $display("FAIL rst_seg_a got %h exp 00", if_a.seg); else n_pass++;
    n_checks++; if (if_a.dig_sel !== 2'b00) $display("FAIL rst_dig_a got %b exp 00", if_a.dig_sel); else n_pass++;
    n_checks++; if (if_b.count !== 16'h0000) $display("FAIL rst_count_b got %h exp 0000", if_b.count); else n_pass++;
    n_checks++; if (if_b.dig_sel !== 4'b0000) $display("FAIL rst_dig_b got %b exp 0000", if_b.dig_sel); else n_pass++;
    idle_inputs();
    reset = 1'b0;
    step();
    n_checks++; if (if_a.dig_sel !== 2'b01) $display("FAIL first_dig_a got %b exp 01", if_a.dig_sel); else n_pass++;
    n_checks++; if (if_a.seg !== 7'h3F) $display("FAIL first_seg_a got %h exp 3f", if_a.seg); else n_pass++;
    n_checks++; if (if_b.dig_sel !== 4'b0001) $display("FAIL first_dig_b got %b exp 0001", if_b.dig_sel); else n_pass++;
    n_checks++; if (if_b.seg !== 7'h3F) $display("FAIL first_seg_b got %h exp 3f", if_b.seg); else n_pass++;
  endtask

  task automatic test_reset_mid_prescale();
    do_reset();
    if_a.en = 1'b1;
    step();
    step();
    reset = 1'b1; if_a.load = 1'b1; if_a.load_val = 8'h77;
    step();
    n_checks++; if (if_a.count !== 8'h00) $display("FAIL rst_ovr_count got %h exp 00", if_a.count); else n_pass++;
    n_checks++; if (if_a.tick !== 1'b0) $display("FAIL rst_ovr_tick got %b exp 0", if_a.tick); else n_pass++;
    reset = 1'b0; if_a.load = 1'b0;
    step();
    step();
    n_checks++; if (if_a.tick !== 1'b0) $display("FAIL rst_presc_early got %b exp 0", if_a.tick); else n_pass++;
    step();
    n_checks++; if (if_a.tick !== 1'b1) $display("FAIL rst_presc_tick got %b exp 1", if_a.tick); else n_pass++;
    if_a.en = 1'b0;
  endtask

  task automatic test_count_up();
    do_reset();
    if_a.en = 1'b1; if_a.up_dn = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      n_checks++; if (if_a.tick !== 1'b0) $display("FAIL up_tick_lo1 k=%0d got %b exp 0", k, if_a.tick); else n_pass++;
      step();
      n_checks++; if (if_a.tick !== 1'b0) $display("FAIL up_tick_lo2 k=%0d got %b exp 0", k, if_a.tick); else n_pass++;
      step();
      n_checks++; if (if_a.tick !== 1'b1) $display("FAIL up_tick k=%0d got %b exp 1", k, if_a.tick); else n_pass++;
      n_checks++; if (if_a.wrap !== (k == 99)) $display("FAIL up_wrap k=%0d got %b exp %b", k, if_a.wrap, (k == 99)); else n_pass++;
      step();
      n_checks++; if (if_a.count !== bcd2((k + 1) % 100)) $display("FAIL up_count k=%0d got %h exp %h", k, if_a.count, bcd2((k + 1) % 100)); else n_pass++;
    end
    if_a.en = 1'b0;
  endtask

  task automatic test_count_down();
    logic [7:0] exp_cnt [3];
    logic       exp_wrap [3];
    exp_cnt  = '{8'h99, 8'h98, 8'h97};
    exp_wrap = '{1'b1, 1'b0, 1'b0};
    do_reset();
    if_a.en = 1'b1; if_a.up_dn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      step();
      step();
      n_checks++; if (if_a.tick !== 1'b1) $display("FAIL dn_tick k=%0d got %b exp 1", k, if_a.tick); else n_pass++;
      n_checks++; if (if_a.wrap !== exp_wrap[k]) $display("FAIL dn_wrap k=%0d got %b exp %b", k, if_a.wrap, exp_wrap[k]); else n_pass++;
      step();
      n_checks++; if (if_a.count !== exp_cnt[k]) $display("FAIL dn_count k=%0d got %h exp %h", k, if_a.count, exp_cnt[k]); else n_pass++;
    end
    if_a.en = 1'b0;
  endtask

  task automatic test_load_priority();
    do_reset();
    if_a.en = 1'b1; if_a.up_dn = 1'b1;
    step();
    step();
    step();
    n_checks++; if (if_a.tick !== 1'b1) $display("FAIL ld_pre_tick got %b exp 1", if_a.tick); else n_pass++;
    if_a.load = 1'b1; if_a.load_val = 8'h2C;
    #1;
    n_checks++; if (if_a.tick !== 1'b0) $display("FAIL ld_tick got %b exp 0", if_a.tick); else n_pass++;
    n_checks++; if (if_a.wrap !== 1'b0) $display("FAIL ld_wrap got %b exp 0", if_a.wrap); else n_pass++;
    step();
    if_a.load = 1'b0;
    n_checks++; if (if_a.count !== 8'h29) $display("FAIL ld_clamp got %h exp 29", if_a.count); else n_pass++;
    step();
    step();
    n_checks++; if (if_a.tick !== 1'b0) $display("FAIL ld_presc_early got %b exp 0", if_a.tick); else n_pass++;
    step();
    n_checks++; if (if_a.tick !== 1'b1) $display("FAIL ld_presc_tick got %b exp 1", if_a.tick); else n_pass++;
    step();
    n_checks++; if (if_a.count !== 8'h30) $display("FAIL ld_carry got %h exp 30", if_a.count); else n_pass++;
    if_a.en = 1'b0;
  endtask

  task automatic test_radix16();
    do_reset();
    if_b.load = 1'b1; if_b.load_val = 16'hFFFE;
    step();
    if_b.load = 1'b0;
    n_checks++; if (if_b.count !== 16'hFFFE) $display("FAIL hex_load got %h exp fffe", if_b.count); else n_pass++;
    if_b.en = 1'b1; if_b.up_dn = 1'b1;
    step();
    step();
    step();
    n_checks++; if (if_b.tick !== 1'b1) $display("FAIL hex_tick1 got %b exp 1", if_b.tick); else n_pass++;
    n_checks++; if (if_b.wrap !== 1'b0) $display("FAIL hex_wrap1 got %b exp 0", if_b.wrap); else n_pass++;
    step();
    n_checks++; if (if_b.count !== 16'hFFFF) $display("FAIL hex_ff got %h exp ffff", if_b.count); else n_pass++;
    step();
    step();
    step();
    n_checks++; if (if_b.wrap !== 1'b1) $display("FAIL hex_wrap2 got %b exp 1", if_b.wrap); else n_pass++;
    step();
    n_checks++; if (if_b.count !== 16'h0000) $display("FAIL hex_00 got %h exp 0000", if_b.count); else n_pass++;
    if_b.en = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] exp_sel [10];
    exp_sel = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++; if (if_b.dig_sel !== exp_sel[k]) $display("FAIL scan_sel k=%0d got %b exp %b", k, if_b.dig_sel, exp_sel[k]); else n_pass++;
    end
    n_checks++; if (if_b.count !== 16'h0000) $display("FAIL scan_frozen got %h exp 0000", if_b.count); else n_pass++;
  endtask

  task automatic test_seg();
    logic [15:0] pats [4];
    logic [6:0]  exp_seg [4][4];
    int          d;
    pats = '{16'h0005, 16'h0000, 16'hC3E7, 16'h0A00};
    exp_seg = '{'{7'h6D, LZ, LZ, LZ},
                '{7'h3F, LZ, LZ, LZ},
                '{7'h07, 7'h79, 7'h4F, 7'h39},
                '{7'h3F, 7'h3F, 7'h77, LZ}};
    for (int p = 0; p < 4; p++) begin
      if_b.load = 1'b1; if_b.load_val = pats[p];
      step();
      if_b.load = 1'b0;
      step();
      for (int k = 0; k < 8; k++) begin
        step();
        case (if_b.dig_sel)
          4'b0001: d = 0;
          4'b0010: d = 1;
          4'b0100: d = 2;
          4'b1000: d = 3;
          default: d = -1;
        endcase
        n_checks++;
        if (d < 0) $display("FAIL seg_sel p=%0d got %b exp one-hot", p, if_b.dig_sel);
        else if (if_b.seg !== exp_seg[p][d])
          $display("FAIL seg_val p=%0d digit=%0d got %h exp %h", p, d, if_b.seg, exp_seg[p][d]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_reset_mid_prescale();
    test_count_up();
    test_count_down();
    test_load_priority();
    test_radix16();
    test_scan();
    test_seg();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_seg_counter.md
MUX_SEG_COUNTER -- requirements
Module: mux_seg_counter

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of display digits (1..8).
REQ-002 SHALL have parameter RADIX, default 10, per-digit base; legal values 10 or 16 only.
REQ-003 SHALL have parameter TICK_DIV, default 10_000_000, clk cycles per count tick (>=2).
REQ-004 SHALL have parameter SCAN_DIV, default 10_000, clk cycles each digit is driven during scan (>=1).
REQ-005 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  count enable; prescaler holds when low.
REQ-008 SHALL have port up_dn  input  1  1 = count up, 0 = count down.
REQ-009 SHALL have port load  input  1  synchronous load strobe.
REQ-010 SHALL have port load_val  input  4*NUM_DIGITS  packed digit values, digit 0 in bits [3:0].
REQ-011 SHALL have port count  output  4*NUM_DIGITS  registered digit values, same packing.
REQ-012 SHALL have port seg  output  7  registered segments {g,f,e,d,c,b,a}, active-high.
REQ-013 SHALL have port dig_sel  output  NUM_DIGITS  registered one-hot digit enable, active-high.
REQ-014 SHALL have port tick  output  1  one-cycle pulse on each prescaler terminal count.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse when the whole counter wraps.

Function
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 while en=1, hold while en=0, assert tick in the cycle it equals TICK_DIV-1, then return to 0.
REQ-017 On tick, digits SHALL step by one as a cascaded base-RADIX counter, digit 0 least significant, direction per up_dn sampled that cycle.
REQ-018 Up: digit at RADIX-1 SHALL become 0 and carry; all digits RADIX-1 SHALL become all 0 with wrap=1 in the same cycle as the update.
REQ-019 Down: digit at 0 SHALL become RADIX-1 and borrow; all digits 0 SHALL become all RADIX-1 with wrap=1.
REQ-020 load=1 SHALL have priority over tick: digits take load_val, prescaler clears to 0, tick and wrap stay 0 that cycle.
REQ-021 Loaded digit values >= RADIX SHALL be clamped to RADIX-1.
REQ-022 count SHALL reflect digit registers with zero additional latency.
REQ-023 Scan counter SHALL run continuously independent of en, advancing the scan index every SCAN_DIV cycles, index NUM_DIGITS-1 wrapping to 0.
REQ-024 dig_sel and seg SHALL be registered, updating one cycle after the scan index or selected digit changes.
REQ-025 seg SHALL encode hex 0..F: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71 (hex, bit 0=a).

Reset
REQ-026 While reset=1: count=0, prescaler=0, scan index=0, tick=0, wrap=0, seg=00, dig_sel=0.
REQ-027 First cycle after reset deassertion SHALL drive dig_sel bit 0 and seg=3F.
REQ-028 reset SHALL override load and en; reset mid-scan or mid-prescale SHALL abandon all state.

Configuration
REQ-029 Macro LEADING_ZERO_BLANK_EN defined: a digit SHALL show seg=00 when it and all more-significant digits are 0, except digit 0, which always displays.
REQ-030 Macro undefined: every digit SHALL display its value including leading zeros.

Structure
REQ-031 Shared package mux_seg_pkg SHALL hold the 16-entry segment pattern constant table and the digit-width constant (4).
REQ-032 Sub-module hex7_decoder (4-bit value -> 7-bit pattern, combinational) SHALL be instantiated once on the scan-selected digit.

Verification
REQ-033 NUM_DIGITS=2, RADIX=10, TICK_DIV=4, en=1, up_dn=1, from reset -> tick every 4th cycle, count 00->01->...->99->00 with wrap on that tick only.
REQ-034 Same, up_dn=0 from reset -> first tick yields count=99 and wrap=1.
REQ-035 load=1, load_val=0x2C on tick cycle, RADIX=10 -> count=0x29, tick=0, prescaler restarts 0.
REQ-036 RADIX=16, load 0xFE, up -> 0xFF, then 0x00 with wrap.
REQ-037 SCAN_DIV=2, NUM_DIGITS=4 -> dig_sel 0001,0001,0010,0010,0100,...; en=0 keeps scanning, count frozen.
REQ-038 LEADING_ZERO_BLANK_EN, count=0x0005 (4 digits) -> seg 00 on digits 3..1, 6D on digit 0; count=0 -> digit 0 shows 3F.
